// File: rtl/q_serial_tx_if.sv
// Byte write channel into q_serial_tx.
//   din       : byte to enqueue (upstream Q)
//   din_valid : din presented this cycle
//   din_ready : sink can accept this cycle
interface q_serial_tx_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/q_serial_tx.sv
// q_serial_tx: buffers bytes in a small FIFO and sends each one as an
// asynchronous serial frame (start bit, 8 data bits LSB first, stop bit).
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : din / din_valid / din_ready write channel (slave side)
//   tx       : registered serial line, idles high
//   busy     : serializer is sending a frame
//   count    : FIFO occupancy
//   overflow : sticky, a byte was offered while the FIFO was full
module q_serial_tx #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned BIT_CYCLES = 4,
  localparam int unsigned PW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  q_serial_tx_if.slave  bus,
  output logic          tx,
  output logic          busy,
  output logic [PW:0]   count,
  output logic          overflow
);

  localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [7:0]    shreg, shreg_nxt;
  logic [CW-1:0] cyc;
  logic [2:0]    bit_idx;
  logic          cyc_last, fifo_nempty, push, pop, tx_nxt;

  // Ready looks only at registered occupancy; a same-cycle pop does not help.
  assign bus.din_ready = (count < (PW+1)'(DEPTH));
  assign push          = bus.din_valid && bus.din_ready;
  assign fifo_nempty   = (count != '0);
  assign cyc_last      = (cyc == CW'(BIT_CYCLES - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fifo_nempty) state_nxt = START;
      START:   if (cyc_last) state_nxt = DATA;
      DATA:    if (cyc_last && (bit_idx == 3'd7)) state_nxt = STOP;
      STOP:    if (cyc_last) state_nxt = fifo_nempty ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: pop decision, shifter update and next line level
  always_comb begin
    pop       = 1'b0;
    shreg_nxt = shreg;
    tx_nxt    = 1'b1;
    case (state)
      IDLE:    pop = fifo_nempty;
      DATA:    if (cyc_last) shreg_nxt = {1'b0, shreg[7:1]};
      STOP:    pop = cyc_last && fifo_nempty;
      default: ;
    endcase
    if (pop) shreg_nxt = mem[rptr];
    // tx is registered, so it is driven from the state being entered.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  // FIFO storage (no reset needed; occupancy guards reads)
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.din;
  end

  // Pointers, occupancy, bit timing and line register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      shreg    <= '0;
      cyc      <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      count    <= count + (PW+1)'(push) - (PW+1)'(pop);
      overflow <= overflow | (bus.din_valid && !bus.din_ready);
      shreg    <= shreg_nxt;
      tx       <= tx_nxt;
      if (state == IDLE) cyc <= '0;
      else               cyc <= cyc_last ? '0 : cyc + CW'(1);
      if ((state == DATA) && cyc_last) bit_idx <= bit_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_q_serial_tx.sv
// Bench for q_serial_tx: frame-level reference model compared every cycle,
// a line decoder, directed scenarios with literal expectations, and a
// randomized traffic phase.
module tb_q_serial_tx;
  localparam int DEPTH = 4;
  localparam int BC    = 4;
  localparam int FRAME = 10 * BC;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx, busy, overflow;
  logic [2:0] count;

  q_serial_tx_if bus();

  q_serial_tx #(.DEPTH(DEPTH), .BIT_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .tx(tx), .busy(busy), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of bytes and time offset into the current frame.
  logic [7:0] mq[$];
  logic [7:0] sent[$];
  logic [7:0] mcur = 8'h00;
  int         mft  = -1;
  logic       movf = 1'b0;

  task automatic model_reset();
    mq.delete();
    mft  = -1;
    movf = 1'b0;
  endtask

  task automatic model_step();
    int   pre;
    logic acc, pp;
    pre = mq.size();
    acc = bus.din_valid && (pre < DEPTH);
    if (bus.din_valid && !(pre < DEPTH)) movf = 1'b1;
    pp = (pre != 0) && ((mft < 0) || (mft == FRAME - 1));
    if (pp) begin
      mcur = mq.pop_front();
      sent.push_back(mcur);
      mft = 0;
    end else if (mft >= 0) begin
      mft++;
      if (mft == FRAME) mft = -1;
    end
    if (acc) mq.push_back(bus.din);
  endtask

  function automatic logic exp_tx();
    int b;
    if (mft < 0) return 1'b1;
    b = mft / BC;
    if (b == 0) return 1'b0;
    if (b <= 8) return mcur[b-1];
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else     model_step();
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("tx",        32'(tx),            32'(exp_tx()));
      chk("busy",      32'(busy),          32'(mft >= 0));
      chk("count",     32'(count),         32'(mq.size()));
      chk("din_ready", 32'(bus.din_ready), 32'(mq.size() < DEPTH));
      chk("overflow",  32'(overflow),      32'(movf));
    end
  end

  // Line decoder: frame starts at the first low cycle, bits sampled mid-bit.
  logic [7:0] rxq[$];
  logic [7:0] dbyte = 8'h00;
  int         dpos  = -1;

  initial forever begin
    @(negedge clk or posedge rst);
    if (rst) dpos = -1;
    else begin
      if (dpos < 0) begin
        if (tx == 1'b0) dpos = 0;
      end else dpos++;
      if (dpos >= 0) begin
        if ((dpos % BC == BC / 2) && (dpos / BC >= 1) && (dpos / BC <= 8))
          dbyte[dpos/BC - 1] = tx;
        if (dpos == FRAME - 1) begin
          rxq.push_back(dbyte);
          dpos = -1;
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d);
    @(negedge clk);
    bus.din_valid = v;
    bus.din       = d;
  endtask

  task automatic wait_idle(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!busy && count == 3'd0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timeout waiting for idle", nm);
    end
  endtask

  logic pat [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int bcnt, maxc, pct;
    bus.din_valid = 1'b0;
    bus.din       = 8'h00;

    // Reset values, asserted between edges and held
    #1 rst = 1'b1;
    #2;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(bus.din_ready), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_tx", 32'(tx), 32'd1);
      chk("rst_hold_count", 32'(count), 32'd0);
    end
    rst = 1'b0;
    repeat (2) cyc(0, 8'h00);

    // Single byte 0xA5: literal waveform
    rxq.delete();
    cyc(1, 8'hA5);
    cyc(0, 8'h00);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      chk("a5_wave", 32'(tx), 32'(pat[i / BC]));
    end
    @(negedge clk);
    chk("a5_busy_end", 32'(busy), 32'd0);
    chk("a5_count_end", 32'(count), 32'd0);
    chk("a5_rx_n", 32'(rxq.size()), 32'd1);
    if (rxq.size() == 1) chk("a5_rx", 32'(rxq[0]), 32'hA5);

    // Back-to-back frames: busy unbroken for 80 cycles
    rxq.delete();
    cyc(1, 8'h01);
    cyc(1, 8'h80);
    cyc(0, 8'h00);
    bcnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (busy) bcnt++;
      else if (bcnt > 0) break;
      @(negedge clk);
    end
    chk("b2b_busy_cycles", 32'(bcnt), 32'd80);
    chk("b2b_rx_n", 32'(rxq.size()), 32'd2);
    if (rxq.size() == 2) begin
      chk("b2b_rx0", 32'(rxq[0]), 32'h01);
      chk("b2b_rx1", 32'(rxq[1]), 32'h80);
    end

    // Full and overflow
    rxq.delete();
    cyc(1, 8'h10);
    cyc(1, 8'h11);
    cyc(1, 8'h12);
    chk("full_busy_c2", 32'(busy), 32'd1);
    chk("full_count_c2", 32'(count), 32'd1);
    cyc(1, 8'h13);
    cyc(1, 8'h14);
    cyc(1, 8'h15);
    chk("full_count4", 32'(count), 32'd4);
    chk("full_ready0", 32'(bus.din_ready), 32'd0);
    chk("full_ovf_pre", 32'(overflow), 32'd0);
    cyc(0, 8'h00);
    chk("full_ovf_set", 32'(overflow), 32'd1);
    wait_idle("full_idle");
    chk("full_ovf_sticky", 32'(overflow), 32'd1);
    chk("full_rx_n", 32'(rxq.size()), 32'd5);
    for (int i = 0; i < 5 && i < rxq.size(); i++)
      chk("full_rx", 32'(rxq[i]), 32'(8'h10 + i));

    // Reset clears overflow; then paced pushes wrap the pointers
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rxq.delete();
    maxc = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1, 8'(8'h20 + k));
      for (int j = 0; j < FRAME - 1; j++) begin
        cyc(0, 8'h00);
        if (int'(count) > maxc) maxc = int'(count);
      end
    end
    wait_idle("wrap_idle");
    chk("wrap_maxcount", 32'(maxc), 32'd1);
    chk("wrap_ovf", 32'(overflow), 32'd0);
    chk("wrap_rx_n", 32'(rxq.size()), 32'd10);
    for (int i = 0; i < 10 && i < rxq.size(); i++)
      chk("wrap_rx", 32'(rxq[i]), 32'(8'h20 + i));

    // Reset during data bit 3 of the first frame
    rxq.delete();
    cyc(1, 8'hFF);
    cyc(1, 8'h00);
    cyc(0, 8'h00);
    repeat (17) @(negedge clk);
    chk("mid_busy_pre", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_tx", 32'(tx), 32'd1);
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) cyc(0, 8'h00);
    chk("mid_no_frames", 32'(rxq.size()), 32'd0);
    chk("mid_idle", 32'(busy), 32'd0);
    cyc(1, 8'h3C);
    cyc(0, 8'h00);
    wait_idle("mid_idle2");
    chk("mid_rx_n", 32'(rxq.size()), 32'd1);
    if (rxq.size() == 1) chk("mid_rx", 32'(rxq[0]), 32'h3C);

    // Randomized traffic at several offered loads
    rxq.delete();
    sent.delete();
    for (int ph = 0; ph < 4; ph++) begin
      pct = (ph == 0) ? 10 : (ph == 1) ? 30 : (ph == 2) ? 60 : 100;
      for (int i = 0; i < 600; i++)
        cyc(($urandom_range(99) < pct) ? 1'b1 : 1'b0, 8'($urandom));
    end
    cyc(0, 8'h00);
    wait_idle("rand_idle");
    chk("rand_rx_n", 32'(rxq.size()), 32'(sent.size()));
    for (int i = 0; i < rxq.size() && i < sent.size(); i++)
      chk("rand_rx", 32'(rxq[i]), 32'(sent[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/q_serial_tx.md
# q_serial_tx

Downstream consumer of the 8-bit `Q` output of the example_04 register stage. It captures `Q` samples on a valid strobe into a small FIFO and transmits each byte on a single-wire asynchronous serial frame: start bit, 8 data bits LSB first, stop bit. This lets bench and board logic observe the register stage's results on one pin, without a parallel bus.

## Interface

Parameters:
- `DEPTH`, default 4: FIFO entries. Power of two, at least 2.
- `BIT_CYCLES`, default 4: clock cycles per serial bit. Must be at least 1.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `din`, input, 8: byte to enqueue (the upstream `Q`).
- `din_valid`, input, 1: `din` is presented this cycle.
- `din_ready`, output, 1: FIFO can accept; equals `count < DEPTH`, from registered `count`.
- `tx`, output, 1: serial line, registered; idles high.
- `busy`, output, 1: serializer is not in IDLE.
- `count`, output, $clog2(DEPTH)+1: FIFO occupancy, registered.
- `overflow`, output, 1: sticky; set when `din_valid && !din_ready`.

## Operation

Reset behaviour:
- `rst` high forces the following immediately, with no clock needed: `tx=1`, `busy=0`, `count=0`, `din_ready=1`, `overflow=0`, pointers 0, FSM in IDLE, bit and cycle counters 0.
- Reset in the middle of a frame aborts the frame and discards all FIFO contents.

Write path:
- Push occurs on an edge where `din_valid && din_ready`. `din` is stored at the write pointer, which advances modulo DEPTH.
- `din_valid && !din_ready` drops the byte and sets `overflow`. `overflow` stays set until `rst`.
- When full, a pop in the same cycle does not make `din_ready` high in that cycle. `din_ready` is based on the registered `count` only.
- Push and pop on the same edge leave `count` unchanged. Both pointers advance.

Serializer FSM, states IDLE, START, DATA, STOP:
- IDLE:
  - `tx=1`.
  - If `count != 0`, pop the head entry into the shift register and go to START.
- START:
  - `tx=0` for BIT_CYCLES cycles, then go to DATA.
- DATA:
  - `tx` = shift register bit 0. Each bit is held BIT_CYCLES cycles, then the register shifts right.
  - After bit index 7 completes, go to STOP.
- STOP:
  - `tx=1` for BIT_CYCLES cycles.
  - At the end of STOP: if `count != 0`, pop and go directly to START, with no idle gap. Otherwise go to IDLE.
- A frame is always 10 × BIT_CYCLES cycles long.
- FIFO order is strict FIFO. Bytes are never reordered or duplicated.

Arithmetic:
- Pointers are log2(DEPTH) bits and wrap naturally.
- `count` is one bit wider than the pointers, so that it can represent DEPTH.
- The cycle counter counts 0..BIT_CYCLES-1. The bit index counts 0..7.

## Timing

- Push edge k: `count` increments at edge k.
- Pop and START:
  - At edge k+1 the FSM sees `count != 0`, pops, enters START, and `tx` goes to 0.
  - Latency from accepted `din` to start bit = 1 cycle after the push edge.
- Data bit n of a frame begins (1 + n) × BIT_CYCLES cycles after the start bit begins.
- The stop bit begins 9 × BIT_CYCLES cycles after the start bit begins.
- `busy` rises with the START entry. It falls on the edge where STOP ends with the FIFO empty.
- `overflow` asserts on the edge after the rejected cycle. This is the same edge on which an accepted byte would have been written.

## Test plan

1. **Reset values.** Assert `rst` asynchronously between edges -> `tx=1`, `busy=0`, `count=0`, `din_ready=1`, `overflow=0` immediately; nothing changes while `rst` is held.
2. **Single byte.** BIT_CYCLES=4, push 0xA5 once -> one cycle later `tx` shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit held 4 cycles (40-cycle frame). `busy` falls after the stop bit, `count` returns to 0.
3. **Back-to-back frames.** Push 0x01 then 0x80 on consecutive cycles -> two frames totalling 80 cycles with no idle high gap between the first stop bit and the second start bit; data bits decode as 0x01 then 0x80.
4. **Full and overflow.** DEPTH=4, push 0x10..0x15 on six consecutive cycles:
   - 0x10 is popped on the 2nd cycle.
   - `count` reaches 4 after 0x14.
   - 0x15 is dropped: `din_ready=0` on that cycle, `overflow=1` on the next edge and sticky.
   - `tx` emits 0x10, 0x11, 0x12, 0x13, 0x14 in order.
5. **Pointer wrap.** Push 10 bytes 0x20..0x29 paced one per frame (every 40 cycles) -> all 10 received in order, `overflow` stays 0, `count` never exceeds 1.
6. **Reset mid-frame.** Push 0xFF and 0x00, then assert `rst` during data bit 3 of the first frame -> `tx=1` at once, `count=0`, no further frames after `rst` deasserts, and a new push 0x3C is then transmitted correctly.
